lsu_unit: RTL and testbench
===========================

Name: lsu_unit

Overview:
Load/store unit directly downstream of the ALU stage. Takes the effective address (addr_alu_out), store data (rs2) and funct3, and runs one word-wide memory transaction over a ready-handshaked bus. Returns sign/zero-extended load data, or a fault, to the writeback stage. Multi-cycle; the core stalls while busy=1.

Parameters:
TIMEOUT_CYCLES, 255, bus wait cycles before timeout fault (used only with LSU_TIMEOUT_EN); range 1..65535

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request strobe; sampled only when accepting (see Behaviour)
is_store  in  1  1=store, 0=load
funct3  in  3  RV32I load/store width code
addr  in  32  effective byte address
wdata  in  32  store data (rs2)
busy  out  1  transaction in flight (REQ state)
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result; valid when done=1, held until next done
fault  out  1  with done: access rejected/failed
fault_cause  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 timeout
mem_req  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  32  word address, {addr[31:2],2'b00}
mem_wstrb  out  4  byte strobes (0 for loads)
mem_wdata  out  32  lane-replicated store data
mem_ready  in  1  bus completion; for loads, mem_rdata valid in same cycle
mem_rdata  in  32  read word

Behaviour:
- Reset (async assert, sync-clean deassert): state=IDLE; busy, done, fault, mem_req, mem_we=0; fault_cause=0; load_data, mem_addr, mem_wdata, mem_wstrb=0. Reset mid-transaction drops mem_req immediately; no done is produced.
- States: IDLE, REQ, RESP.
- start is accepted in IDLE or RESP; ignored in REQ (no queueing).
- On accept: decode funct3. Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
  - Illegal funct3 -> RESP, fault=1, cause=2, no bus activity.
  - H with addr[0]=1, or W with addr[1:0]!=0 -> RESP, fault=1, cause=1, no bus activity.
  - Illegal funct3 takes priority over misalignment.
  - Otherwise -> REQ, with mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata registered on the same edge.
- Store lane data: SB = {4{wdata[7:0]}}, strb = 4'b0001<<addr[1:0]; SH = {2{wdata[15:0]}}, strb = 4'b0011<<addr[1:0]; SW = wdata, strb = 4'b1111.
- REQ: bus outputs held stable until mem_ready=1. On that edge: mem_req=0, state=RESP, and (loads) load_data = extracted lane, sign-extended (LB/LH) or zero-extended (LBU/LHU/LW). Minimum latency start->done = 2 cycles.
- RESP: done=1 for exactly one cycle, fault/fault_cause valid. Then IDLE, or REQ/RESP again if start accepted (back-to-back, no bubble).
- Stores leave load_data unchanged. Faults force load_data=0.
- mem_ready outside REQ is ignored.
- load_data and fault_cause hold between done pulses; fault is 0 whenever done=0.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a 16-bit counter clears on entry to REQ and increments each REQ cycle with mem_ready=0. When it reaches TIMEOUT_CYCLES: drop mem_req, go to RESP with fault=1, cause=3. mem_ready in that same cycle wins (normal completion).
- Undefined: no counter; REQ waits indefinitely; cause 3 is never produced.

Decomposition:
- Package lsu_pkg: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), state enum, fault_cause codes.
- Sub-module lsu_load_align: combinational; (mem_rdata, addr[1:0], funct3) -> extended 32-bit result.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, mem_ready after 3 wait cycles -> mem_addr=0x100, wstrb=1111, mem_wdata=0xDEADBEEF held stable for 4 cycles; single done, fault=0.
- LB addr=0x203, mem_rdata=0x80FF1234 -> wstrb=0000, load_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x202 -> 0xFFFF80FF.
- SH addr=0x301 -> done 1 cycle after start, fault=1, cause=1, mem_req never asserted; load funct3=011 -> cause=2.
- Back-to-back: second start in the RESP cycle -> mem_req re-asserted next cycle, no IDLE cycle; start pulsed during REQ -> ignored.
- rst_n low during REQ -> mem_req=0 asynchronously, no done; first transaction after reset completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready held 0 -> done with fault=1, cause=3 after 4 REQ cycles; mem_ready arriving on the 4th cycle -> normal completion.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM
// states, fault cause codes and the request-decode helpers.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == SB) || (f3 == SH) || (f3 == SW);
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

  // Halfword codes end in 01; only meaningful once the code is known legal.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3 == LW) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: picks the addressed byte/halfword out of the bus
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the byte and halfword lanes addressed by the low address bits.
  always_comb begin
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  // Extend the selected lane to 32 bits.
  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LBU:     o_data = {24'd0, w_byte};
      LHU:     o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: one word-wide bus transaction per request, with
// misalignment / illegal-width rejection and extended load results.
// Optional feature macro: LSU_TIMEOUT_EN (bus wait timeout, cause 3).
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  generate
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("lsu_unit: TIMEOUT_CYCLES must be in 1..65535");
    end
  endgenerate

  lsu_state_e  r_state, w_state_nxt;
  logic        r_fault;
  logic [1:0]  r_cause;
  logic [31:0] r_load_data;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;

  logic        w_illegal, w_misal, w_launch, w_finish, w_timeout;
  logic        w_resp_fault;
  logic [1:0]  w_resp_cause;
  logic [31:0] w_st_data, w_ext;
  logic [3:0]  w_st_strb;

  assign w_illegal = !f3_legal(is_store, funct3);
  assign w_misal   = f3_misaligned(funct3, addr[1:0]);

`ifdef LSU_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic [15:0] w_tmo_inc;
  assign w_tmo_inc = r_tmo_cnt + 16'd1;
  assign w_timeout = (r_state == ST_REQ) && !mem_ready && (w_tmo_inc == 16'(TIMEOUT_CYCLES));

  // Count unanswered REQ cycles; restarts with every new bus request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_tmo_cnt <= 16'd0;
    else if (w_launch)                          r_tmo_cnt <= 16'd0;
    else if ((r_state == ST_REQ) && !mem_ready) r_tmo_cnt <= w_tmo_inc;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Store lane replication and byte strobes from width and address offset.
  always_comb begin
    w_st_data = wdata;
    w_st_strb = 4'b1111;
    case (funct3)
      SB:      begin w_st_data = {4{wdata[7:0]}};  w_st_strb = 4'b0001 << addr[1:0]; end
      SH:      begin w_st_data = {2{wdata[15:0]}}; w_st_strb = 4'b0011 << addr[1:0]; end
      default: begin w_st_data = wdata;            w_st_strb = 4'b1111;              end
    endcase
  end

  lsu_load_align u_align (
    .i_rdata   (mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_ext)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus the fault outcome of the cycle; mem_ready beats a timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_resp_fault = 1'b0;
    w_resp_cause = CAUSE_NONE;
    w_launch     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (mem_ready) begin
          w_state_nxt = ST_RESP;
          w_finish    = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt  = ST_RESP;
          w_finish     = 1'b1;
          w_resp_fault = 1'b1;
          w_resp_cause = CAUSE_TIMEOUT;
        end
      end
      default: begin
        if (!start) begin
          w_state_nxt = ST_IDLE;
        end else if (w_illegal || w_misal) begin
          w_state_nxt  = ST_RESP;
          w_resp_fault = 1'b1;
          w_resp_cause = w_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
        end else begin
          w_state_nxt = ST_REQ;
          w_launch    = 1'b1;
        end
      end
    endcase
  end

  // Bus request registers and result registers updated on launch/response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault     <= 1'b0;
      r_cause     <= CAUSE_NONE;
      r_load_data <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
    end else begin
      r_fault <= (w_state_nxt == ST_RESP) && w_resp_fault;
      if (w_state_nxt == ST_RESP) begin
        r_cause <= w_resp_cause;
        if (w_resp_fault)   r_load_data <= 32'd0;
        else if (!r_mem_we) r_load_data <= w_ext;
      end
      if (w_launch) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= is_store;
        r_mem_addr  <= {addr[31:2], 2'b00};
        r_mem_wstrb <= is_store ? w_st_strb : 4'b0000;
        r_mem_wdata <= w_st_data;
        r_funct3    <= funct3;
        r_addr_lo   <= addr[1:0];
      end else if (w_finish) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
    end
  end

  assign busy        = (r_state == ST_REQ);
  assign done        = (r_state == ST_RESP);
  assign fault       = r_fault;
  assign fault_cause = r_cause;
  assign load_data   = r_load_data;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wstrb   = r_mem_wstrb;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit; timeout scenario built with LSU_TIMEOUT_EN.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_cause;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .load_data(load_data), .fault(fault), .fault_cause(fault_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then withdraw start.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    step();
    start = 1'b0;
  endtask

  // Answer the outstanding request this cycle.
  task automatic answer(input logic [31:0] rd);
    mem_ready = 1'b1; mem_rdata = rd;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (fault !== 1'b0 || fault_cause !== 2'd0) begin n_bad++; $display("FAIL rst_fault: got %b/%0d want 0/0", fault, fault_cause); end
    n_cmp++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_bus: got req %b we %b want 0 0", mem_req, mem_we); end
    n_cmp++; if (load_data !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wstrb !== 4'd0) begin n_bad++; $display("FAIL rst_data: got %h %h %h %h want zeros", load_data, mem_addr, mem_wdata, mem_wstrb); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_store_sw();
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL sw_req_%0d: got req %b we %b busy %b done %b want 1 1 1 0", i, mem_req, mem_we, busy, done); end
      n_cmp++; if (mem_addr !== 32'h100 || mem_wstrb !== 4'hF || mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_bus_%0d: got %h %h %h want 00000100 f deadbeef", i, mem_addr, mem_wstrb, mem_wdata); end
      if (i < 3) step();
    end
    answer(32'h0);
    n_cmp++; if (done !== 1'b1 || fault !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL sw_done: got done %b fault %b req %b busy %b want 1 0 0 0", done, fault, mem_req, busy); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL sw_single_done: got %b want 0", done); end
  endtask

  task automatic test_loads();
    issue(1'b0, 3'b000, 32'h203, 32'hFFFFFFFF);
    n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_wstrb !== 4'h0 || mem_addr !== 32'h200) begin n_bad++; $display("FAIL lb_bus: got req %b we %b strb %h addr %h want 1 0 0 00000200", mem_req, mem_we, mem_wstrb, mem_addr); end
    answer(32'h80FF1234);
    n_cmp++; if (done !== 1'b1 || fault !== 1'b0 || load_data !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_data: got %b %b %h want 1 0 ffffff80", done, fault, load_data); end
    issue(1'b0, 3'b100, 32'h203, 32'h0);
    answer(32'h80FF1234);
    n_cmp++; if (load_data !== 32'h00000080) begin n_bad++; $display("FAIL lbu_data: got %h want 00000080", load_data); end
    issue(1'b0, 3'b001, 32'h202, 32'h0);
    answer(32'h80FF1234);
    n_cmp++; if (load_data !== 32'hFFFF80FF) begin n_bad++; $display("FAIL lh_data: got %h want ffff80ff", load_data); end
    issue(1'b0, 3'b101, 32'h200, 32'h0);
    answer(32'h80FF8234);
    n_cmp++; if (load_data !== 32'h00008234) begin n_bad++; $display("FAIL lhu_data: got %h want 00008234", load_data); end
    issue(1'b0, 3'b010, 32'h204, 32'h0);
    n_cmp++; if (mem_addr !== 32'h204) begin n_bad++; $display("FAIL lw_addr: got %h want 00000204", mem_addr); end
    answer(32'h80FF1234);
    n_cmp++; if (load_data !== 32'h80FF1234) begin n_bad++; $display("FAIL lw_data: got %h want 80ff1234", load_data); end
  endtask

  task automatic test_sub_stores();
    issue(1'b1, 3'b000, 32'h103, 32'h000000A5);
    n_cmp++; if (mem_wstrb !== 4'b1000 || mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h100) begin n_bad++; $display("FAIL sb_bus: got %h %h %h want 8 a5a5a5a5 00000100", mem_wstrb, mem_wdata, mem_addr); end
    answer(32'h0);
    n_cmp++; if (done !== 1'b1 || load_data !== 32'h80FF1234) begin n_bad++; $display("FAIL sb_keep_data: got %b %h want 1 80ff1234", done, load_data); end
    issue(1'b1, 3'b001, 32'h102, 32'h1234BEEF);
    n_cmp++; if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'hBEEFBEEF) begin n_bad++; $display("FAIL sh_bus: got %h %h want c beefbeef", mem_wstrb, mem_wdata); end
    answer(32'h0);
    step();
  endtask

  task automatic test_faults();
    issue(1'b1, 3'b001, 32'h301, 32'h0);
    n_cmp++; if (done !== 1'b1 || fault !== 1'b1 || fault_cause !== 2'd1) begin n_bad++; $display("FAIL misal: got %b %b %0d want 1 1 1", done, fault, fault_cause); end
    n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0 || load_data !== 32'd0) begin n_bad++; $display("FAIL misal_nobus: got req %b busy %b data %h want 0 0 0", mem_req, busy, load_data); end
    step();
    n_cmp++; if (done !== 1'b0 || fault !== 1'b0 || fault_cause !== 2'd1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL misal_after: got %b %b %0d %b want 0 0 1 0", done, fault, fault_cause, mem_req); end
    issue(1'b0, 3'b011, 32'h0, 32'h0);
    n_cmp++; if (done !== 1'b1 || fault !== 1'b1 || fault_cause !== 2'd2 || mem_req !== 1'b0) begin n_bad++; $display("FAIL illegal_ld: got %b %b %0d %b want 1 1 2 0", done, fault, fault_cause, mem_req); end
    issue(1'b1, 3'b101, 32'h301, 32'h0);
    n_cmp++; if (done !== 1'b1 || fault !== 1'b1 || fault_cause !== 2'd2) begin n_bad++; $display("FAIL illegal_prio: got %b %b %0d want 1 1 2", done, fault, fault_cause); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 3'b010, 32'h400, 32'h0);
    issue(1'b1, 3'b010, 32'h500, 32'h55555555);
    n_cmp++; if (busy !== 1'b1 || mem_addr !== 32'h400 || mem_we !== 1'b0) begin n_bad++; $display("FAIL b2b_ignore: got busy %b addr %h we %b want 1 00000400 0", busy, mem_addr, mem_we); end
    answer(32'h11223344);
    n_cmp++; if (done !== 1'b1 || load_data !== 32'h11223344) begin n_bad++; $display("FAIL b2b_first: got %b %h want 1 11223344", done, load_data); end
    issue(1'b1, 3'b010, 32'h500, 32'hCAFEF00D);
    n_cmp++; if (mem_req !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || mem_addr !== 32'h500 || mem_wdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL b2b_second: got req %b busy %b done %b addr %h wd %h", mem_req, busy, done, mem_addr, mem_wdata); end
    answer(32'h0);
    n_cmp++; if (done !== 1'b1 || fault !== 1'b0) begin n_bad++; $display("FAIL b2b_done: got %b %b want 1 0", done, fault); end
    step();
    n_cmp++; if (done !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b %b %b want 0 0 0", done, mem_req, busy); end
    mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ready_idle: got done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 3'b010, 32'h600, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_async: got req %b busy %b want 0 0", mem_req, busy); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_nodone: got %b want 0", done); end
    #2 rst_n = 1'b1;
    step();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got %b %b want 0 0", done, busy); end
    issue(1'b0, 3'b100, 32'h601, 32'h0);
    answer(32'h0000AB00);
    n_cmp++; if (done !== 1'b1 || fault !== 1'b0 || load_data !== 32'h000000AB) begin n_bad++; $display("FAIL rstmid_after: got %b %b %h want 1 0 000000ab", done, fault, load_data); end
    step();
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    issue(1'b0, 3'b010, 32'h700, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (done !== 1'b0 || mem_req !== 1'b1) begin n_bad++; $display("FAIL tmo_wait_%0d: got done %b req %b want 0 1", i, done, mem_req); end
    end
    step();
    n_cmp++; if (done !== 1'b1 || fault !== 1'b1 || fault_cause !== 2'd3 || mem_req !== 1'b0 || load_data !== 32'd0) begin n_bad++; $display("FAIL tmo_fault: got %b %b %0d %b %h want 1 1 3 0 0", done, fault, fault_cause, mem_req, load_data); end
    step();
    issue(1'b0, 3'b010, 32'h700, 32'h0);
    step(); step(); step();
    answer(32'h0BADF00D);
    n_cmp++; if (done !== 1'b1 || fault !== 1'b0 || fault_cause !== 2'd0 || load_data !== 32'h0BADF00D) begin n_bad++; $display("FAIL tmo_race: got %b %b %0d %h want 1 0 0 0badf00d", done, fault, fault_cause, load_data); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_store_sw();
    test_loads();
    test_sub_stores();
    test_faults();
    test_back_to_back();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
